count_monitor: RTL and testbench
================================

# count_monitor

Receive-side checker for the saturating up-counter stream. It samples a counter's data word whenever `Valid_i` is high and verifies the sequence:
- the first sample equals `InitVal`;
- each later sample is the previous sample plus one, up to `EndVal`;
- after `EndVal`, the value stays at `EndVal`.

It sits on the consumer side of any counter output in the design and reports progress, completion and a sticky, classified error with the offending value.

## Interface
Parameters:
- `InitVal`, default 0: expected first value.
- `EndVal`, default 32: expected final, saturating value. `InitVal <= EndVal` is required; elaboration fails otherwise.

Ports:
- `Clk_i`  in  1  clock, rising edge.
- `Reset_i`  in  1  asynchronous reset, active-high.
- `Valid_i`  in  1  `Data_i` is a sample this cycle.
- `Data_i`  in  32  counter value under check.
- `Busy_o`  out  1  first sample accepted, `EndVal` not yet seen.
- `Done_o`  out  1  `EndVal` reached with no error.
- `Error_o`  out  1  sticky error flag.
- `ErrCode_o`  out  2  error class: 0 none, 1 START, 2 STEP, 3 HOLD.
- `ErrData_o`  out  32  `Data_i` value that caused the error.
- `Count_o`  out  32  accepted samples; saturates at all-ones.

## Operation
- FSM states: IDLE, COUNT, DONE, ERROR. Reset state is IDLE.
- IDLE, on `Valid_i`:
  - `Data_i == InitVal` and `InitVal == EndVal`: go to DONE.
  - `Data_i == InitVal` otherwise: go to COUNT.
  - else: go to ERROR with code START.
- COUNT, on `Valid_i`:
  - `Data_i == Prev+1` and `Data_i == EndVal`: go to DONE.
  - `Data_i == Prev+1` otherwise: stay in COUNT.
  - else: go to ERROR with code STEP. This includes out-of-range values and a wrap to 0.
- DONE, on `Valid_i`:
  - `Data_i == EndVal`: stay in DONE.
  - else: go to ERROR with code HOLD.
- ERROR: absorbing. Only reset leaves it. `ErrCode_o` and `ErrData_o` are frozen.
- When `Valid_i` is low, nothing changes: state, Prev and Count all hold.
- Prev is a 32-bit register loaded with `Data_i` on every accepted sample.
- Prev+1 is computed 33 bits wide, so `Data_i = 0` after Prev = 0xFFFFFFFF is a STEP error, never a wrap match.
- `Count_o` increments on every accepted sample, i.e. `Valid_i` in IDLE, COUNT or DONE that does not cause an error.
- Output decoding:
  - `Busy_o` = (state == COUNT).
  - `Done_o` = (state == DONE).
  - `Error_o` = (state == ERROR).

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N, i.e. 1-cycle latency.
- Reset values: all outputs 0, state IDLE, Prev 0.
- Reset is asserted asynchronously and released synchronously to `Clk_i`.
- Reset mid-run clears everything. The first `Valid_i` after release is again checked against `InitVal`.
- There is no backpressure: `Valid_i` can be high every cycle, and every valid sample is checked.
- A sample arriving in the same cycle the state is entered is checked against the new state on the next edge. There are no skipped checks.

## Configuration
- Macro: `COUNT_MONITOR_HOLD_EN`.
- Defined: in COUNT, `Data_i == Prev` is accepted as a stall. The state stays COUNT, Prev is unchanged and `Count_o` still increments. This supports counters with a clock enable.
- Undefined: a repeated value in COUNT is a STEP error.
- DONE behaviour is identical either way.

## Structure
- Package `count_monitor_pkg` holds:
  - the state enum typedef (IDLE, COUNT, DONE, ERROR);
  - the 2-bit error-code typedef and constants ERR_NONE, ERR_START, ERR_STEP, ERR_HOLD;
  - the data width constant (32).
- No sub-module. The FSM, compare and capture logic fit naturally in one module.
- The parameter sanity check lives in a generate-time assertion.

## Test plan
All scenarios use `InitVal=8`, `EndVal=64`.
1. Reset, then `Valid_i` every cycle with 8,9,…,64,64,64. Expected: `Busy_o` is 1 from the cycle after 8; `Done_o` rises one cycle after 64; `Count_o` = 59; `Error_o` = 0.
2. First valid sample is 9. Expected: next cycle `Error_o` = 1, `ErrCode_o` = 1, `ErrData_o` = 9; further samples are ignored.
3. Sequence 8,9,11. Expected: `ErrCode_o` = 2, `ErrData_o` = 11, `Count_o` = 2.
4. Sequence 8…64, then 65. Expected: `Done_o` drops and `Error_o` = 1, with `ErrCode_o` = 3 and `ErrData_o` = 65.
5. Sequence 8,9,9,10:
   - with `COUNT_MONITOR_HOLD_EN` defined: no error, `Count_o` = 4;
   - with it undefined: `ErrCode_o` = 2 and `ErrData_o` = 9.
6. Reset asserted mid-run after 8..20, then 8,9. Expected: outputs are 0 during reset; after release, `Busy_o` = 1 and `Count_o` = 2 with no error. Also gap `Valid_i` low for 5 cycles between samples and check that state is held.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and constants for the counter-stream checker.
// Holds the FSM state encoding, the error classification and the data width.
// Imported by count_monitor.
package count_monitor_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE  = 2'd0;
  localparam err_code_t ERR_START = 2'd1;
  localparam err_code_t ERR_STEP  = 2'd2;
  localparam err_code_t ERR_HOLD  = 2'd3;

endpackage

// File: rtl/count_monitor.sv
// count_monitor: checks a saturating up-counter stream (InitVal..EndVal, then hold) and flags a sticky classified error.
// Latency: 1 cycle, every output is a register updated on the edge that samples Valid_i/Data_i.
// Backpressure: none, a sample may arrive every cycle and each one is checked. Optional macro COUNT_MONITOR_HOLD_EN accepts repeats in COUNT as stalls.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter logic [DATA_W-1:0] InitVal = 32'd0,
  parameter logic [DATA_W-1:0] EndVal  = 32'd32
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Valid_i,
  input  logic [DATA_W-1:0] Data_i,
  output logic              Busy_o,
  output logic              Done_o,
  output logic              Error_o,
  output err_code_t         ErrCode_o,
  output logic [DATA_W-1:0] ErrData_o,
  output logic [DATA_W-1:0] Count_o
);

  // A descending sequence cannot be checked; refuse to elaborate.
  if (InitVal > EndVal) begin : g_param_check
    $error("count_monitor: InitVal must not exceed EndVal");
  end

  state_t            state_q;
  logic [DATA_W-1:0] prev_q;

  logic [DATA_W:0]   prev_inc;
  logic [DATA_W-1:0] count_inc;
  logic              init_ok;
  logic              step_ok;
  logic              end_ok;
  logic              hold_ok;

  // Sample comparisons; the increment is one bit wider so 0xFFFFFFFF+1 never matches 0.
  always_comb begin
    prev_inc  = {1'b0, prev_q} + {{DATA_W{1'b0}}, 1'b1};
    init_ok   = (Data_i == InitVal);
    step_ok   = ({1'b0, Data_i} == prev_inc);
    end_ok    = (Data_i == EndVal);
    count_inc = (Count_o == {DATA_W{1'b1}}) ? Count_o : Count_o + 1'b1;
`ifdef COUNT_MONITOR_HOLD_EN
    // A clock-enabled counter may repeat its value; treat that as a stall.
    hold_ok   = (Data_i == prev_q);
`else
    hold_ok   = 1'b0;
`endif
  end

  // Checker FSM with registered status, capture and sample counter.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      Busy_o    <= 1'b0;
      Done_o    <= 1'b0;
      Error_o   <= 1'b0;
      ErrCode_o <= ERR_NONE;
      ErrData_o <= '0;
      Count_o   <= '0;
    end else if (Valid_i) begin
      case (state_q)
        IDLE: begin
          if (init_ok) begin
            prev_q  <= Data_i;
            Count_o <= count_inc;
            if (InitVal == EndVal) begin
              state_q <= DONE;
              Done_o  <= 1'b1;
            end else begin
              state_q <= COUNT;
              Busy_o  <= 1'b1;
            end
          end else begin
            state_q   <= ERROR;
            Error_o   <= 1'b1;
            ErrCode_o <= ERR_START;
            ErrData_o <= Data_i;
          end
        end
        COUNT: begin
          if (step_ok) begin
            prev_q  <= Data_i;
            Count_o <= count_inc;
            if (end_ok) begin
              state_q <= DONE;
              Busy_o  <= 1'b0;
              Done_o  <= 1'b1;
            end
          end else if (hold_ok) begin
            // Stall: Prev already equals the sample, only the count moves.
            Count_o <= count_inc;
          end else begin
            state_q   <= ERROR;
            Busy_o    <= 1'b0;
            Error_o   <= 1'b1;
            ErrCode_o <= ERR_STEP;
            ErrData_o <= Data_i;
          end
        end
        DONE: begin
          if (end_ok) begin
            prev_q  <= Data_i;
            Count_o <= count_inc;
          end else begin
            state_q   <= ERROR;
            Done_o    <= 1'b0;
            Error_o   <= 1'b1;
            ErrCode_o <= ERR_HOLD;
            ErrData_o <= Data_i;
          end
        end
        default: begin
          // ERROR is absorbing; capture registers stay frozen until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed checks of count_monitor with InitVal=8, EndVal=64.
module tb_count_monitor;
  import count_monitor_pkg::*;

  logic        Clk_i;
  logic        Reset_i;
  logic        Valid_i;
  logic [31:0] Data_i;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;
  err_code_t   ErrCode_o;
  logic [31:0] ErrData_o;
  logic [31:0] Count_o;

  int checks = 0;
  int errors = 0;

  count_monitor #(.InitVal(32'd8), .EndVal(32'd64)) dut (
    .Clk_i     (Clk_i),
    .Reset_i   (Reset_i),
    .Valid_i   (Valid_i),
    .Data_i    (Data_i),
    .Busy_o    (Busy_o),
    .Done_o    (Done_o),
    .Error_o   (Error_o),
    .ErrCode_o (ErrCode_o),
    .ErrData_o (ErrData_o),
    .Count_o   (Count_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [31:0] edat;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done, input logic err,
                         input logic [1:0] code, input logic [31:0] edat, input logic [31:0] cnt);
    check({tag, ".busy"},    {31'd0, Busy_o},    {31'd0, busy});
    check({tag, ".done"},    {31'd0, Done_o},    {31'd0, done});
    check({tag, ".error"},   {31'd0, Error_o},   {31'd0, err});
    check({tag, ".errcode"}, {30'd0, ErrCode_o}, {30'd0, code});
    check({tag, ".errdata"}, ErrData_o,          edat);
    check({tag, ".count"},   Count_o,            cnt);
  endtask

  // Drive one cycle at the falling edge, then settle just past the rising edge.
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge Clk_i);
    Valid_i = v;
    Data_i  = d;
    @(posedge Clk_i);
    #1;
  endtask

  // Assert reset between edges, confirm the asynchronous clear, release at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge Clk_i);
    Valid_i = 1'b0;
    Data_i  = '0;
    Reset_i = 1'b1;
    #1;
    chk_all({tag, ".in_reset"}, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge Clk_i);
    Reset_i = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] first, input logic [31:0] last);
    for (int v = int'(first); v <= int'(last); v++) step(1'b1, 32'(v));
  endtask

  initial begin
    Reset_i = 1'b1;
    Valid_i = 1'b0;
    Data_i  = '0;

    // Bad start, then a broken step; error state must stay frozen afterwards.
    tbl[0] = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 2'd0, 32'd0,  32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 2'd1, 32'd9,  32'd0};
    tbl[2] = '{1'b0, 1'b1, 32'd8,  1'b0, 1'b0, 1'b1, 2'd1, 32'd9,  32'd0};
    tbl[3] = '{1'b0, 1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 2'd1, 32'd9,  32'd0};
    tbl[4] = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 2'd0, 32'd0,  32'd0};
    tbl[5] = '{1'b0, 1'b1, 32'd8,  1'b1, 1'b0, 1'b0, 2'd0, 32'd0,  32'd1};
    tbl[6] = '{1'b0, 1'b1, 32'd9,  1'b1, 1'b0, 1'b0, 2'd0, 32'd0,  32'd2};
    tbl[7] = '{1'b0, 1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 2'd2, 32'd11, 32'd2};
    tbl[8] = '{1'b0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1, 2'd2, 32'd11, 32'd2};

    #2;
    chk_all("reset_state", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

    // Table-driven start/step errors.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
      else            step(tbl[i].vld, tbl[i].dat);
      chk_all($sformatf("tbl%0d", i), tbl[i].busy, tbl[i].done, tbl[i].err,
              tbl[i].code, tbl[i].edat, tbl[i].cnt);
    end

    // Full legal run with saturation hold.
    do_reset("s1");
    step(1'b1, 32'd8);
    chk_all("s1_first", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd1);
    run_to(32'd9, 32'd63);
    chk_all("s1_at63", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd56);
    step(1'b1, 32'd64);
    chk_all("s1_at64", 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd57);
    step(1'b1, 32'd64);
    step(1'b1, 32'd64);
    chk_all("s1_hold", 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd59);

    // Leaving EndVal after completion.
    do_reset("s4");
    run_to(32'd8, 32'd64);
    step(1'b1, 32'd65);
    chk_all("s4_hold_err", 1'b0, 1'b0, 1'b1, 2'd3, 32'd65, 32'd57);
    step(1'b1, 32'd64);
    chk_all("s4_frozen", 1'b0, 1'b0, 1'b1, 2'd3, 32'd65, 32'd57);

    // Repeated value while counting.
    do_reset("s5");
    step(1'b1, 32'd8);
    step(1'b1, 32'd9);
    step(1'b1, 32'd9);
    step(1'b1, 32'd10);
`ifdef COUNT_MONITOR_HOLD_EN
    chk_all("s5_stall", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd4);
`else
    chk_all("s5_repeat", 1'b0, 1'b0, 1'b1, 2'd2, 32'd9, 32'd2);
`endif

    // Mid-run reset, then restart with an idle gap.
    do_reset("s6a");
    run_to(32'd8, 32'd20);
    chk_all("s6_pre", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd13);
    do_reset("s6b");
    step(1'b0, 32'd0);
    chk_all("s6_released", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    step(1'b1, 32'd8);
    for (int g = 0; g < 5; g++) step(1'b0, 32'd99);
    chk_all("s6_gap", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd1);
    step(1'b1, 32'd9);
    chk_all("s6_resume", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd2);
    step(1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
